alu_imm_sequencer: RTL and testbench

- Sequences OP-IMM instructions (ADDI, SLTI, SLTIU, XORI, ORI, ANDI) through the registered register-immediate ALU in the minimal RV32I core.
- Accepts an instruction word over a valid/ready handshake and decodes rd, rs1 and funct3.
- Sign-extends imm12, reads rs1 from the register file and holds the ALU enabled and its inputs stable for the ALU's latency.
- Captures the result and presents it to register-file writeback over a second valid/ready handshake.

---
 rtl/alu_imm_pkg.sv | 22 ++
 rtl/alu_imm_decode.sv | 27 ++
 rtl/alu_imm_sequencer.sv | 143 ++++++++++++++
 tb/tb_alu_imm_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_imm_pkg.sv
// Shared constants and FSM state type for the OP-IMM sequencer.
package alu_imm_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADDI  = 3'd0;
    localparam logic [2:0] F3_SLLI  = 3'd1; // unsupported: shift
    localparam logic [2:0] F3_SLTI  = 3'd2;
    localparam logic [2:0] F3_SLTIU = 3'd3;
    localparam logic [2:0] F3_XORI  = 3'd4;
    localparam logic [2:0] F3_SRXI  = 3'd5; // unsupported: shift
    localparam logic [2:0] F3_ORI   = 3'd6;
    localparam logic [2:0] F3_ANDI  = 3'd7;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StExec,
        StWb
    } state_e;

endpackage

// File: rtl/alu_imm_decode.sv
// Combinational OP-IMM field extraction, imm12 sign extension and legality check.
module alu_imm_decode
    import alu_imm_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic [31:0]           instr_i,
    output logic [REG_ADDR_W-1:0] rd_o,
    output logic [REG_ADDR_W-1:0] rs1_o,
    output logic [2:0]            funct3_o,
    output logic [XLEN-1:0]       imm_o,
    output logic                  legal_o
);

    logic [6:0] opcode;

    assign opcode   = instr_i[6:0];
    assign rd_o     = instr_i[7 +: REG_ADDR_W];
    assign funct3_o = instr_i[14:12];
    assign rs1_o    = instr_i[15 +: REG_ADDR_W];
    assign imm_o    = {{(XLEN - 12){instr_i[31]}}, instr_i[31:20]};

    // The attached ALU has no shifter, so the shift-immediate encodings are rejected.
    assign legal_o = (opcode == OP_IMM) && (funct3_o != F3_SLLI) && (funct3_o != F3_SRXI);

endmodule

// File: rtl/alu_imm_sequencer.sv
// Sequences one OP-IMM instruction at a time: decode, RF read, registered ALU, writeback.
module alu_imm_sequencer
    import alu_imm_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    input  logic                  instr_valid_i,
    output logic                  instr_ready_o,
    input  logic [31:0]           instr_i,
    output logic [REG_ADDR_W-1:0] rf_rs1_addr_o,
    input  logic [XLEN-1:0]       rf_rs1_data_i,
    output logic                  alu_enable_o,
    output logic [2:0]            alu_funct3_o,
    output logic [XLEN-1:0]       alu_rs1_o,
    output logic [XLEN-1:0]       alu_immediate_o,
    input  logic [XLEN-1:0]       alu_rd_value_i,
    output logic                  wb_valid_o,
    input  logic                  wb_ready_i,
    output logic [REG_ADDR_W-1:0] wb_rd_o,
    output logic [XLEN-1:0]       wb_value_o,
    output logic                  illegal_o,
    output logic                  busy_o
);

    localparam int unsigned CntW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY + 1) : 1;

    logic [REG_ADDR_W-1:0] dec_rd;
    logic [REG_ADDR_W-1:0] dec_rs1;
    logic [2:0]            dec_funct3;
    logic [XLEN-1:0]       dec_imm;
    logic                  dec_legal;

    state_e                state_q;
    logic [CntW-1:0]       cnt_q;
    logic                  instr_ready_q;
    logic [REG_ADDR_W-1:0] rf_rs1_addr_q;
    logic                  alu_enable_q;
    logic [2:0]            funct3_q;
    logic [XLEN-1:0]       rs1_val_q;
    logic [XLEN-1:0]       imm_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  wb_valid_q;
    logic [REG_ADDR_W-1:0] wb_rd_q;
    logic [XLEN-1:0]       wb_value_q;
    logic                  illegal_q;

    alu_imm_decode #(
        .XLEN       (XLEN),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_decode (
        .instr_i  (instr_i),
        .rd_o     (dec_rd),
        .rs1_o    (dec_rs1),
        .funct3_o (dec_funct3),
        .imm_o    (dec_imm),
        .legal_o  (dec_legal)
    );

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            instr_ready_q <= 1'b0;
            rf_rs1_addr_q <= '0;
            alu_enable_q  <= 1'b0;
            funct3_q      <= '0;
            rs1_val_q     <= '0;
            imm_q         <= '0;
            rd_q          <= '0;
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= '0;
            wb_value_q    <= '0;
            illegal_q     <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (instr_valid_i && instr_ready_q && dec_legal) begin
                        rd_q          <= dec_rd;
                        funct3_q      <= dec_funct3;
                        imm_q         <= dec_imm;
                        rf_rs1_addr_q <= dec_rs1;
                        instr_ready_q <= 1'b0;
                        state_q       <= StRead;
                    end else begin
                        // Also raises ready on the first edge after reset release.
                        instr_ready_q <= 1'b1;
                        if (instr_valid_i && instr_ready_q) begin
                            illegal_q <= 1'b1;
                        end
                    end
                end
                StRead: begin
                    rs1_val_q    <= rf_rs1_data_i;
                    alu_enable_q <= 1'b1;
                    cnt_q        <= CntW'(ALU_LATENCY);
                    state_q      <= StExec;
                end
                StExec: begin
                    if (cnt_q == '0) begin
                        wb_value_q   <= alu_rd_value_i;
                        alu_enable_q <= 1'b0;
                        if (rd_q != '0) begin
                            wb_valid_q <= 1'b1;
                            wb_rd_q    <= rd_q;
                            state_q    <= StWb;
                        end else begin
                            instr_ready_q <= 1'b1;
                            state_q       <= StIdle;
                        end
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StWb: begin
                    if (wb_ready_i) begin
                        wb_valid_q    <= 1'b0;
                        instr_ready_q <= 1'b1;
                        state_q       <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign instr_ready_o   = instr_ready_q;
    assign rf_rs1_addr_o   = rf_rs1_addr_q;
    assign alu_enable_o    = alu_enable_q;
    assign alu_funct3_o    = funct3_q;
    assign alu_rs1_o       = rs1_val_q;
    assign alu_immediate_o = imm_q;
    assign wb_valid_o      = wb_valid_q;
    assign wb_rd_o         = wb_rd_q;
    assign wb_value_o      = wb_value_q;
    assign illegal_o       = illegal_q;
    assign busy_o          = (state_q != StIdle);

endmodule

// File: tb/tb_alu_imm_sequencer.sv
// Directed, table-driven bench for alu_imm_sequencer with a register-file and registered ALU model.
module tb_alu_imm_sequencer;

    typedef struct {
        logic [11:0] imm;
        logic [4:0]  rs1;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] rs1_val;
        logic [31:0] exp_val;
        int          hold;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [4:0]  rf_rs1_addr;
    logic [31:0] rf_rs1_data;
    logic        alu_enable;
    logic [2:0]  alu_funct3;
    logic [31:0] alu_rs1;
    logic [31:0] alu_immediate;
    logic [31:0] alu_rd_value;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_value;
    logic        illegal;
    logic        busy;

    logic [31:0] rf [32];
    logic [31:0] alu_q;
    int          n_total = 0;
    int          n_pass  = 0;
    vec_t        vecs [8];

    alu_imm_sequencer #(
        .XLEN        (32),
        .REG_ADDR_W  (5),
        .ALU_LATENCY (1)
    ) dut (
        .clock_i         (clk),
        .reset_n_i       (reset_n),
        .instr_valid_i   (instr_valid),
        .instr_ready_o   (instr_ready),
        .instr_i         (instr),
        .rf_rs1_addr_o   (rf_rs1_addr),
        .rf_rs1_data_i   (rf_rs1_data),
        .alu_enable_o    (alu_enable),
        .alu_funct3_o    (alu_funct3),
        .alu_rs1_o       (alu_rs1),
        .alu_immediate_o (alu_immediate),
        .alu_rd_value_i  (alu_rd_value),
        .wb_valid_o      (wb_valid),
        .wb_ready_i      (wb_ready),
        .wb_rd_o         (wb_rd),
        .wb_value_o      (wb_value),
        .illegal_o       (illegal),
        .busy_o          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rf_rs1_data = rf[rf_rs1_addr];

    // Registered ALU, latency 1; a poison value stands in for Z while disabled.
    always_ff @(posedge clk) begin
        if (alu_enable) begin
            case (alu_funct3)
                3'd0:    alu_q <= alu_rs1 + alu_immediate;
                3'd2:    alu_q <= {31'd0, $signed(alu_rs1) < $signed(alu_immediate)};
                3'd3:    alu_q <= {31'd0, alu_rs1 < alu_immediate};
                3'd4:    alu_q <= alu_rs1 ^ alu_immediate;
                3'd6:    alu_q <= alu_rs1 | alu_immediate;
                3'd7:    alu_q <= alu_rs1 & alu_immediate;
                default: alu_q <= 32'hBAD0_BAD0;
            endcase
        end
    end
    assign alu_rd_value = alu_enable ? alu_q : 32'hDEAD_BEEF;

    function automatic logic [31:0] enc(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic run_instr(input vec_t v, input string tag);
        logic [31:0] exp_imm;
        int          en_cnt = 0;
        int          wb_cnt = 0;
        int          ret = 0;
        logic [4:0]  addr_seen = '0;
        logic [31:0] imm_seen = '0;
        logic [31:0] rs1_seen = '0;
        logic [2:0]  f3_seen = '0;
        logic [4:0]  rd_seen = '0;
        logic [31:0] val_seen = '0;
        bit          stable = 1'b1;
        bit          ill = 1'b0;
        exp_imm = {{20{v.imm[11]}}, v.imm};
        rf[v.rs1] = v.rs1_val;
        wb_ready = (v.hold == 0);
        chk({tag, ".ready_in"}, {31'd0, instr_ready}, 32'd1);
        instr = enc(v.imm, v.rs1, v.f3, v.rd, 7'b0010011);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        for (int n = 1; n <= 30 && ret == 0; n++) begin
            if (n == 1) addr_seen = rf_rs1_addr;
            if (alu_enable) begin
                en_cnt++;
                imm_seen = alu_immediate;
                rs1_seen = alu_rs1;
                f3_seen  = alu_funct3;
            end
            if (illegal) ill = 1'b1;
            if (wb_valid) begin
                wb_cnt++;
                if (wb_cnt == 1) begin
                    rd_seen  = wb_rd;
                    val_seen = wb_value;
                end else if (wb_rd != rd_seen || wb_value != val_seen) begin
                    stable = 1'b0;
                end
                wb_ready = (wb_cnt > v.hold);
            end
            if (instr_ready) ret = n;
            else @(negedge clk);
        end
        chk({tag, ".rs1_addr"}, {27'd0, addr_seen}, {27'd0, v.rs1});
        chk({tag, ".en_cycles"}, en_cnt, 32'd2);
        chk({tag, ".alu_imm"}, imm_seen, exp_imm);
        chk({tag, ".alu_rs1"}, rs1_seen, v.rs1_val);
        chk({tag, ".alu_f3"}, {29'd0, f3_seen}, {29'd0, v.f3});
        chk({tag, ".illegal"}, {31'd0, ill}, 32'd0);
        if (v.rd != 5'd0) begin
            chk({tag, ".wb_cycles"}, wb_cnt, v.hold + 1);
            chk({tag, ".wb_rd"}, {27'd0, rd_seen}, {27'd0, v.rd});
            chk({tag, ".wb_value"}, val_seen, v.exp_val);
            chk({tag, ".wb_stable"}, {31'd0, stable}, 32'd1);
            chk({tag, ".accept_gap"}, ret, 5 + v.hold);
        end else begin
            chk({tag, ".wb_cycles"}, wb_cnt, 32'd0);
            chk({tag, ".accept_gap"}, ret, 32'd4);
        end
        wb_ready = 1'b1;
    endtask

    task automatic run_illegal(input logic [31:0] word, input string tag);
        chk({tag, ".ready_in"}, {31'd0, instr_ready}, 32'd1);
        instr = word;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        chk({tag, ".pulse"}, {31'd0, illegal}, 32'd1);
        chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
        chk({tag, ".alu_en"}, {31'd0, alu_enable}, 32'd0);
        chk({tag, ".ready"}, {31'd0, instr_ready}, 32'd1);
        @(negedge clk);
        chk({tag, ".pulse_end"}, {31'd0, illegal}, 32'd0);
    endtask

    initial begin
        vec_t xori;
        int   wb_seen;
        // imm, rs1, f3, rd, rs1_val, expected, wb_ready hold
        vecs[0] = '{12'hFFF, 5'd1,  3'd0, 5'd5,  32'd5,          32'd4,          0};
        vecs[1] = '{12'hFFF, 5'd2,  3'd3, 5'd3,  32'd7,          32'd1,          0};
        vecs[2] = '{12'hFFF, 5'd2,  3'd2, 5'd3,  32'd7,          32'd0,          0};
        vecs[3] = '{12'h003, 5'd1,  3'd0, 5'd0,  32'd5,          32'd8,          0};
        vecs[4] = '{12'h0F0, 5'd7,  3'd7, 5'd6,  32'h1234_5678,  32'h0000_0070,  3};
        vecs[5] = '{12'hF00, 5'd9,  3'd6, 5'd8,  32'h0000_00AB,  32'hFFFF_FFAB,  0};
        vecs[6] = '{12'h7FF, 5'd11, 3'd4, 5'd10, 32'h0000_0800,  32'h0000_0FFF,  0};
        vecs[7] = '{12'h005, 5'd13, 3'd2, 5'd12, 32'hFFFF_FFFF,  32'd1,          0};
        xori    = '{12'h0F0, 5'd1,  3'd4, 5'd4,  32'h0000_00FF,  32'h0000_000F,  0};

        for (int i = 0; i < 32; i++) rf[i] = '0;
        reset_n     = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        wb_ready    = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk("reset.ctrl", {27'd0, instr_ready, alu_enable, wb_valid, illegal, busy}, 32'd0);
        chk("reset.wb_value", wb_value, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_instr(vecs[i], $sformatf("vec%0d", i));
            if (i == 3) begin
                run_illegal(enc(12'h001, 5'd1, 3'd1, 5'd5, 7'b0010011), "slli");
                run_illegal({7'd0, 5'd2, 5'd1, 3'd0, 5'd5, 7'b0110011}, "add_reg");
            end
        end

        // Reset asserted mid-EXEC aborts the instruction.
        rf[1] = 32'd5;
        chk("abort.ready_in", {31'd0, instr_ready}, 32'd1);
        instr = enc(12'hFFF, 5'd1, 3'd0, 5'd5, 7'b0010011);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("abort.in_exec", {31'd0, alu_enable}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort.ctrl", {27'd0, instr_ready, alu_enable, wb_valid, illegal, busy}, 32'd0);
        chk("abort.alu_rs1", alu_rs1, 32'd0);
        chk("abort.alu_imm", alu_immediate, 32'd0);
        chk("abort.rs1_addr", {27'd0, rf_rs1_addr}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        wb_seen = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (wb_valid) wb_seen++;
        end
        chk("abort.no_wb", wb_seen, 32'd0);
        run_instr(xori, "xori_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
